uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
UART receive frame controller. It is the neighbouring stage on both sides of the RX majority-vote sampler: it drives the sampler's Enable and Edge_count, and consumes its Sampled_bit.
- Detects the start bit, qualifies it and deserializes 8 data bits LSB-first.
- Checks optional parity and the stop bit.
- Presents the byte on P_DATA with a one-cycle Data_Valid pulse.

Parameters:
DATA_WIDTH, 8, data bits per frame (fixed at 8 for this revision)
PRESC_WIDTH, 6, width of the Prescale input

Ports:
CLK  in  1  oversampling clock, single clock domain
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, pre-synchronized, idle high
Prescale  in  6  oversampling ratio; legal values are 8, 16 and 32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
Sampled_bit  in  1  majority-voted bit from the sampler
Enable  out  1  sampler enable
Edge_count  out  5  oversample edge index within the current bit
P_DATA  out  8  last good received byte
Data_Valid  out  1  one-cycle pulse when P_DATA is updated
Parity_Error  out  1  one-cycle pulse at end of a frame with bad parity
Stop_Error  out  1  one-cycle pulse at end of a frame with stop bit = 0

Behaviour:
- Reset values: all outputs 0, state IDLE, bit counter 0, shift register 0. Reset is async assert, sync deassert inside the RST tree.
- Reset mid-frame aborts the frame immediately. P_DATA returns to 0 and no pulses are emitted.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - Enable=0, Edge_count=0.
  - On a CLK edge with RX_IN=0: latch Prescale, PAR_EN and PAR_TYP into shadow registers, go to START, set Edge_count to 1. That cycle counts as edge 0.
- Non-IDLE states
  - Enable=1. Edge_count increments each cycle.
  - At Edge_count == latched Prescale-1 (the bit end), Sampled_bit is evaluated and Edge_count wraps to 0.
  - Prescale changes mid-frame have no effect.
- START: at bit end, Sampled_bit=1 means a glitch: return to IDLE with no pulses. Sampled_bit=0 goes to DATA with bit counter 0.
- DATA: at each bit end, shift Sampled_bit in LSB-first and increment the bit counter. After the 8th bit, go to PARITY if PAR_EN, else STOP.
- PARITY
  - Expected bit = XOR of the 8 data bits, XOR PAR_TYP.
  - Mismatch sets an internal par_err flag. Go to STOP regardless.
- STOP: at bit end, Sampled_bit=0 sets stp_err. Then go to IDLE. On the same clock edge the outputs register:
  - Data_Valid = !(par_err | stp_err)
  - Parity_Error = par_err
  - Stop_Error = stp_err
  - P_DATA = shift register, only if Data_Valid
- All pulses are high for exactly the one cycle after the stop-bit evaluation edge. par_err and stp_err clear on the next entry to START.
- Frame length from the first low RX_IN sample to the Data_Valid cycle is 10×Prescale cycles without parity, 11×Prescale with parity.
- Back-to-back frames: the next start bit is detected from IDLE on the cycle after STOP exits. This costs at most 1 oversample cycle of alignment.
- Sampler timing: the sampler captures at edges Prescale/2-2 .. Prescale/2. Evaluation at Prescale-1 therefore always sees a settled vote.
- Illegal Prescale (anything other than 8/16/32) is unsupported. The counter still wraps at Prescale-1, but correctness is not guaranteed.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - PAR_EVEN=0 and PAR_ODD=1
  - legal prescale constants PRESC_8, PRESC_16, PRESC_32
- One sub-module, uart_rx_edge_bit_counter. Inputs: CLK, RST, enable, the latched prescale. Outputs: Edge_count, bit_end, and the bit counter with clear.
- The FSM, deserializer and parity/stop check stay in uart_rx_frame_ctrl.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 -> single Data_Valid pulse 80 cycles after start, P_DATA=0xA5, no error pulses.
- Prescale=16, even parity, 0x3C with parity bit 0 -> Data_Valid at cycle 176, P_DATA=0x3C. The same frame with parity bit 1 -> Parity_Error pulse, Data_Valid=0, P_DATA stays 0x3C.
- Prescale=8, odd parity, 0x01 with stop bit 0 -> Stop_Error pulse, Parity_Error=0, P_DATA unchanged.
- Prescale=16, RX_IN low for 3 cycles then high -> START rejects the glitch, return to IDLE, no pulses, Enable low again after 16 cycles.
- Prescale=32, back-to-back frames 0x00 then 0xFF with no idle gap -> two Data_Valid pulses 320 cycles apart (±1), P_DATA 0x00 then 0xFF.
- RST asserted during the DATA state of a 0x55 frame -> all outputs 0 immediately. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int PRESC_WIDTH   = 6;
    localparam int EDGE_WIDTH    = 5;
    localparam int BIT_CNT_WIDTH = 4;

    // Index of the final data bit; reaching it at a bit end closes the data phase.
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [PRESC_WIDTH-1:0] PRESC_8  = 6'd8;
    localparam logic [PRESC_WIDTH-1:0] PRESC_16 = 6'd16;
    localparam logic [PRESC_WIDTH-1:0] PRESC_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity bit a correct transmitter would send for this byte.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic par_typ);
        return (par_typ == PAR_EVEN) ? ^data : ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Received-byte output bundle of the frame controller, plus its FSM state for observation.
// Data_Valid, Parity_Error and Stop_Error are single-cycle strobes with no backpressure:
// the consumer must take P_DATA in the cycle Data_Valid is high; P_DATA holds until the next good frame.
interface uart_rx_frame_ctrl_if;
    import uart_rx_pkg::*;

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Parity_Error;
    logic                  Stop_Error;
    rx_state_t             state;

    modport master (output P_DATA, Data_Valid, Parity_Error, Stop_Error, state);
    modport slave  (input  P_DATA, Data_Valid, Parity_Error, Stop_Error, state);

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter (wraps at the latched prescale) and data-bit counter.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enable,
    input  logic [PRESC_WIDTH-1:0]   prescale,
    input  logic                     bit_clr,
    input  logic                     bit_inc,
    output logic [EDGE_WIDTH-1:0]    Edge_count,
    output logic                     bit_end,
    output logic [BIT_CNT_WIDTH-1:0] bit_cnt
);

    logic [PRESC_WIDTH-1:0] last_edge;

    assign last_edge = prescale - PRESC_WIDTH'(1);
    assign bit_end   = enable && ({1'b0, Edge_count} == last_edge);

    // Edge index: counts while enabled, wraps at the bit end, parks at 0 otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Edge_count <= '0;
        end else if (!enable || bit_end) begin
            Edge_count <= '0;
        end else begin
            Edge_count <= Edge_count + EDGE_WIDTH'(1);
        end
    end

    // Number of data bits shifted so far in the current frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
        end else if (bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start qualification, LSB-first deserialization,
// parity and stop checks, and result strobes.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   Sampled_bit,
    output logic                   Enable,
    output logic [EDGE_WIDTH-1:0]  Edge_count,
    uart_rx_frame_ctrl_if.master   frame
);

    logic [1:0]               rst_sync;
    logic                     rst_n;
    rx_state_t                state_q, state_d;
    logic [PRESC_WIDTH-1:0]   presc_q;
    logic                     par_en_q, par_typ_q;
    logic [DATA_WIDTH-1:0]    shreg;
    logic                     par_err;
    logic                     stp_err;
    logic [DATA_WIDTH-1:0]    p_data_q;
    logic                     dv_q, pe_q, se_q;
    logic                     cnt_en, bit_end, bit_clr, bit_inc;
    logic                     start_det, shift_en, par_chk, stop_chk;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;

    // Reset asserts immediately and releases two clocks after RST rises.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    uart_rx_edge_bit_counter u_counter (
        .CLK        (CLK),
        .RST        (rst_n),
        .enable     (cnt_en),
        .prescale   (presc_q),
        .bit_clr    (bit_clr),
        .bit_inc    (bit_inc),
        .Edge_count (Edge_count),
        .bit_end    (bit_end),
        .bit_cnt    (bit_cnt)
    );

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; everything but start detection waits for a bit end.
    always_comb begin
        state_d   = state_q;
        cnt_en    = 1'b1;
        start_det = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        case (state_q)
            IDLE: begin
                // The detecting cycle is edge 0, so the counter starts on it.
                cnt_en = !RX_IN;
                if (!RX_IN) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    if (Sampled_bit) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_clr = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    bit_inc  = 1'b1;
                    if (bit_cnt == LAST_DATA_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_chk = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stop_chk = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The stop verdict is needed on the same edge that registers the result strobes.
    assign stp_err = stop_chk && !Sampled_bit;

    // Frame settings are shadowed at start so mid-frame input changes are ignored.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            shreg     <= '0;
            par_err   <= 1'b0;
        end else begin
            if (start_det) begin
                presc_q   <= Prescale;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_err   <= 1'b0;
            end
            if (shift_en) begin
                shreg <= {Sampled_bit, shreg[DATA_WIDTH-1:1]};
            end
            if (par_chk) begin
                par_err <= (Sampled_bit != parity_bit(shreg, par_typ_q));
            end
        end
    end

    // Result strobes last one cycle; P_DATA only takes error-free frames.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            p_data_q <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            if (stop_chk) begin
                dv_q <= !(par_err || stp_err);
                pe_q <= par_err;
                se_q <= stp_err;
                if (!(par_err || stp_err)) begin
                    p_data_q <= shreg;
                end
            end
        end
    end

    assign Enable             = (state_q != IDLE);
    assign frame.P_DATA       = p_data_q;
    assign frame.Data_Valid   = dv_q;
    assign frame.Parity_Error = pe_q;
    assign frame.Stop_Error   = se_q;
    assign frame.state        = state_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: a mid-bit majority sampler model feeds Sampled_bit,
// frames are generated bit by bit, and every result strobe is compared with a frame-level model.
module tb_uart_rx_frame_ctrl;
    import uart_rx_pkg::*;

    localparam int W = 43;  // {cycle[31:0], dv, pe, se, p_data[7:0]}

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = PRESC_8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       Sampled_bit = 1'b1;
    logic       Enable;
    logic [4:0] Edge_count;

    uart_rx_frame_ctrl_if frame_bus();

    uart_rx_frame_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Sampled_bit (Sampled_bit),
        .Enable      (Enable),
        .Edge_count  (Edge_count),
        .frame       (frame_bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_p = 8;
    logic [7:0] last_good = 8'h00;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    logic s0 = 1'b1, s1 = 1'b1, s2 = 1'b1;

    // Clock and reset block.
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Sampler model: votes three line samples around mid-bit.
    always @(posedge CLK) begin
        #2;
        if (Enable) begin
            if (int'(Edge_count) == cur_p / 2 - 2) s0 = RX_IN;
            if (int'(Edge_count) == cur_p / 2 - 1) s1 = RX_IN;
            if (int'(Edge_count) == cur_p / 2) begin
                s2 = RX_IN;
                Sampled_bit = (s0 & s1) | (s0 & s2) | (s1 & s2);
            end
        end
    end

    // Record every cycle in which any result strobe is high.
    always @(negedge CLK) begin
        if (frame_bus.Data_Valid || frame_bus.Parity_Error || frame_bus.Stop_Error)
            act_q.push_back({32'(cyc), frame_bus.Data_Valid, frame_bus.Parity_Error,
                             frame_bus.Stop_Error, frame_bus.P_DATA});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_enable"}, 64'(Enable), 64'(0));
        check({tag, "_edge_count"}, 64'(Edge_count), 64'(0));
        check({tag, "_p_data"}, 64'(frame_bus.P_DATA), 64'(0));
        check({tag, "_data_valid"}, 64'(frame_bus.Data_Valid), 64'(0));
        check({tag, "_parity_error"}, 64'(frame_bus.Parity_Error), 64'(0));
        check({tag, "_stop_error"}, 64'(frame_bus.Stop_Error), 64'(0));
        check({tag, "_state"}, 64'(frame_bus.state), 64'(IDLE));
    endtask

    // Drive one frame starting now (just after an edge) and queue the expected result.
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                              input logic par_typ, input logic bad_par, input logic stop_bit,
                              input logic [5:0] mid_presc);
        logic line_q[$];
        logic sent_par;
        logic pe, se, dv;
        int   ones;
        int   start_cyc;
        cur_p    = p;
        Prescale = 6'(p);
        PAR_EN   = par_en;
        PAR_TYP  = par_typ;
        ones     = $countones(data);
        // A correct transmitter makes the total count of ones even (even parity) or odd (odd parity).
        sent_par = ((ones % 2) != int'(par_typ)) ^ bad_par;
        line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) line_q.push_back(data[i]);
        if (par_en) line_q.push_back(sent_par);
        line_q.push_back(stop_bit);
        pe = par_en && (((ones + int'(sent_par)) % 2) != int'(par_typ));
        se = !stop_bit;
        dv = !pe && !se;
        if (dv) last_good = data;
        start_cyc = cyc;
        exp_q.push_back({32'(start_cyc + line_q.size() * p), dv, pe, se, last_good});
        foreach (line_q[i]) begin
            RX_IN = line_q[i];
            repeat (p) @(posedge CLK);
            #1;
            if (i == 0) Prescale = mid_presc;
        end
        RX_IN = 1'b1;
    endtask

    // Compare recorded strobes against the expected queue, then confirm the line is quiet.
    task automatic drain(input string tag);
        repeat (4) @(posedge CLK);
        #1;
        check({tag, "_pulse_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0)
            check({tag, "_pulse"}, 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        act_q.delete();
        check({tag, "_p_data_hold"}, 64'(frame_bus.P_DATA), 64'(last_good));
        check({tag, "_enable_idle"}, 64'(Enable), 64'(0));
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        RST = 1'b1;
        repeat (4) sync();

        // Prescale 8, no parity, 0xA5: Data_Valid 80 cycles after start.
        send_frame(8'hA5, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_16);
        drain("p8_a5");

        // Prescale 16, even parity: good parity, then flipped parity bit.
        send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, PRESC_8);
        drain("p16_even_ok");
        send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, PRESC_16);
        drain("p16_even_bad");

        // Prescale 8, odd parity, stop bit low.
        send_frame(8'h01, 8, 1'b1, PAR_ODD, 1'b0, 1'b0, PRESC_8);
        drain("p8_odd_stop0");

        // Start-bit glitch: low for 3 cycles at prescale 16.
        cur_p = 16;
        Prescale = PRESC_16;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        sync();
        check("glitch_enable_on", 64'(Enable), 64'(1));
        check("glitch_edge_first", 64'(Edge_count), 64'(1));
        repeat (2) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        check("glitch_enable_held", 64'(Enable), 64'(1));
        sync();
        check("glitch_enable_off", 64'(Enable), 64'(0));
        check("glitch_state", 64'(frame_bus.state), 64'(IDLE));
        check("glitch_edge_zero", 64'(Edge_count), 64'(0));
        drain("glitch");

        // Prescale 32 back-to-back frames, no idle gap.
        sync();
        send_frame(8'h00, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_8);
        send_frame(8'hFF, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_16);
        drain("p32_b2b");

        // Reset during the data phase of 0x55, then a clean 0x81.
        cur_p = 8;
        Prescale = PRESC_8;
        RX_IN = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("abort_in_data", 64'(frame_bus.state), 64'(DATA));
        RST = 1'b0;
        #1;
        check_idle_outputs("abort");
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        last_good = 8'h00;
        repeat (4) sync();
        drain("abort_quiet");
        send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, PRESC_8);
        drain("after_abort");

        // Randomized frames with random gaps, including back-to-back.
        for (int n = 0; n < 24; n++) begin
            int   p;
            int   gap;
            logic pen;
            p   = 8 << $urandom_range(0, 2);
            pen = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge CLK);
                #1;
            end
            send_frame(8'($urandom_range(0, 255)), p, pen, 1'($urandom_range(0, 1)),
                       pen && ($urandom_range(0, 3) == 0), $urandom_range(0, 5) != 0,
                       6'($urandom_range(1, 63)));
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
